regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (reg_write / write_reg / write_data) between two write-back requesters: req0 (ALU result) and req1 (load/memory result).
- Performs round-robin arbitration with a valid/ready handshake on each requester.
- Registers the winner into one output stage that drives the regfile write port directly.
- Sits between the execute/memory stages and regfile; also keeps a committed-write counter for debug.

---
 rtl/regfile_wb_arbiter_pkg.sv | 22 ++
 rtl/regfile_wb_arbiter_rr_arbiter2.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 87 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter and the register file it feeds.
package regfile_wb_arbiter_pkg;

   // Widths shared with the register file
   localparam int unsigned RF_DATA_WIDTH    = 16;
   localparam int unsigned RF_REGADDR_WIDTH = 3;
   localparam int unsigned WR_CNT_WIDTH     = 16;

   // Requester indices into the grant vector
   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_MEM = 1'b1;

   // Two-way round-robin: a lone requester wins, a tie goes to whoever did not win last
   function automatic logic [1:0] rr2_grant(input logic [1:0] req, input logic last);
      logic [1:0] gnt;
      gnt          = 2'b00;
      gnt[REQ_ALU] = req[REQ_ALU] && (!req[REQ_MEM] || (last == REQ_MEM));
      gnt[REQ_MEM] = req[REQ_MEM] && (!req[REQ_ALU] || (last == REQ_ALU));
      return gnt;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with its last-grant pointer; reusable for any shared port.
module rr_arbiter2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       hold,
   output logic [1:0] gnt_c,
   output logic       last_grant
);

   logic last_q;
   logic last_d;

   // Grant is blocked in reset and while held; the pointer moves only on a grant
   always_comb begin
      gnt_c  = 2'b00;
      last_d = last_q;
      if (!reset && !hold) begin
         gnt_c = rr2_grant(req, last_q);
         if (gnt_c[REQ_MEM]) begin
            last_d = REQ_MEM;
         end else if (gnt_c[REQ_ALU]) begin
            last_d = REQ_ALU;
         end
      end
   end

   // Pointer resets to the load side so the ALU wins the first tie
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= REQ_MEM;
      end else begin
         last_q <= last_d;
      end
   end

   assign last_grant = last_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and load write-back paths.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = regfile_wb_arbiter_pkg::RF_DATA_WIDTH,
   parameter int unsigned REGADDR_WIDTH = regfile_wb_arbiter_pkg::RF_REGADDR_WIDTH,
   parameter int unsigned CNT_WIDTH     = regfile_wb_arbiter_pkg::WR_CNT_WIDTH
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req0_valid,
   input  logic [REGADDR_WIDTH-1:0] req0_reg,
   input  logic [DATA_WIDTH-1:0]    req0_data,
   output logic                     req0_ready,
   input  logic                     req1_valid,
   input  logic [REGADDR_WIDTH-1:0] req1_reg,
   input  logic [DATA_WIDTH-1:0]    req1_data,
   output logic                     req1_ready,
   input  logic                     wb_hold,
   output logic                     reg_write,
   output logic [REGADDR_WIDTH-1:0] write_reg,
   output logic [DATA_WIDTH-1:0]    write_data,
   output logic                     last_grant,
   output logic [CNT_WIDTH-1:0]     wr_count
);

   logic [1:0] gnt_c;

   logic                     reg_write_q,  reg_write_d;
   logic [REGADDR_WIDTH-1:0] write_reg_q,  write_reg_d;
   logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
   logic [CNT_WIDTH-1:0]     wr_count_q,   wr_count_d;

   rr_arbiter2 u_arb (
      .clk        (clk),
      .reset      (reset),
      .req        ({req1_valid, req0_valid}),
      .hold       (wb_hold),
      .gnt_c      (gnt_c),
      .last_grant (last_grant)
   );

   // Ready is the grant itself: a transfer happens exactly when the arbiter picks a requester
   assign req0_ready = gnt_c[REQ_ALU];
   assign req1_ready = gnt_c[REQ_MEM];

   // Output stage captures the winner; address/data hold when idle, counter tracks issued writes
   always_comb begin
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      wr_count_d   = wr_count_q + CNT_WIDTH'(reg_write_q);
      if (gnt_c[REQ_ALU]) begin
         reg_write_d  = 1'b1;
         write_reg_d  = req0_reg;
         write_data_d = req0_data;
      end else if (gnt_c[REQ_MEM]) begin
         reg_write_d  = 1'b1;
         write_reg_d  = req1_reg;
         write_data_d = req1_data;
      end
   end

   // Reset drops any pending write along with the counter
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         wr_count_q   <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         wr_count_q   <= wr_count_d;
      end
   end

   assign reg_write  = reg_write_q;
   assign write_reg  = write_reg_q;
   assign write_data = write_data_q;
   assign wr_count   = wr_count_q;

   // Never more than one grant per cycle
   a_one_grant : assert property (@(posedge clk) !(req0_ready && req1_ready));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: scoreboard of granted writes plus a behavioural regfile for readback.
module tb_regfile_wb_arbiter;

   typedef struct packed {
      logic [2:0]  r;
      logic [15:0] d;
   } sb_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0, wb_hold = 1'b0;
   logic [2:0]  req0_reg = '0, req1_reg = '0;
   logic [15:0] req0_data = '0, req1_data = '0;
   logic        req0_ready, req1_ready, reg_write, last_grant;
   logic [2:0]  write_reg;
   logic [15:0] write_data;
   logic [15:0] wr_count;

   int total = 0;
   int bad   = 0;

   sb_t         sbq[$];
   int          glog[$];
   logic [15:0] rf     [8];
   logic [15:0] rf_exp [8];
   logic        mon_en = 1'b0;
   logic        last_exp = 1'b1;
   logic        rw_exp = 1'b0;
   logic [15:0] cnt_exp = '0;

   regfile_wb_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_reg   (req0_reg),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_reg   (req1_reg),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .wb_hold    (wb_hold),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .last_grant (last_grant),
      .wr_count   (wr_count)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 8; i++) begin
         rf[i]     = '0;
         rf_exp[i] = '0;
      end
   end

   // Behavioural register file; a write coinciding with reset is dropped
   always @(posedge clk) begin
      if (reg_write && !reset) rf[write_reg] <= write_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model and scoreboard, evaluated mid-cycle while inputs are stable
   always @(negedge clk) begin
      logic e_r0, e_r1;
      sb_t  e;
      if (mon_en) begin
         e_r0 = !reset && !wb_hold && req0_valid && (!req1_valid || last_exp);
         e_r1 = !reset && !wb_hold && req1_valid && (!req0_valid || !last_exp);
         chk("ready0", 32'(req0_ready), 32'(e_r0));
         chk("ready1", 32'(req1_ready), 32'(e_r1));
         chk("last_grant", 32'(last_grant), 32'(last_exp));
         chk("reg_write", 32'(reg_write), 32'(rw_exp));
         chk("wr_count", 32'(wr_count), 32'(cnt_exp));
         if (reg_write) begin
            if (sbq.size() == 0) begin
               chk("sb_underflow", 32'(1), 32'(0));
            end else begin
               e = sbq.pop_front();
               chk("write_reg", 32'(write_reg), 32'(e.r));
               chk("write_data", 32'(write_data), 32'(e.d));
               if (!reset) rf_exp[e.r] = e.d;
            end
         end
         if (req0_valid && req0_ready) glog.push_back(0);
         if (req1_valid && req1_ready) glog.push_back(1);
         if (reset) begin
            rw_exp   = 1'b0;
            cnt_exp  = '0;
            last_exp = 1'b1;
         end else begin
            if (rw_exp) cnt_exp = cnt_exp + 16'd1;
            rw_exp = e_r0 || e_r1;
            if (e_r0) begin
               sbq.push_back('{r: req0_reg, d: req0_data});
               last_exp = 1'b0;
            end
            if (e_r1) begin
               sbq.push_back('{r: req1_reg, d: req1_data});
               last_exp = 1'b1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [2:0] r, input logic [15:0] d);
      bit done = 0;
      req0_valid = 1'b1;
      req0_reg   = r;
      req0_data  = d;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (req0_ready) done = 1;
         step();
      end
      if (!done) chk("timeout0", 32'(0), 32'(1));
      req0_valid = 1'b0;
   endtask

   task automatic send1(input logic [2:0] r, input logic [15:0] d);
      bit done = 0;
      req1_valid = 1'b1;
      req1_reg   = r;
      req1_data  = d;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (req1_ready) done = 1;
         step();
      end
      if (!done) chk("timeout1", 32'(0), 32'(1));
      req1_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      glog.delete();
   endtask

   task automatic check_alternating(input string tag, input int n);
      chk({tag, "_ngrants"}, 32'(glog.size()), 32'(n));
      for (int i = 0; i < n && i < glog.size(); i++)
         chk({tag, "_order"}, 32'(glog[i]), 32'(i % 2));
   endtask

   task automatic check_rf();
      for (int i = 0; i < 8; i++) chk("rf_model", 32'(rf[i]), 32'(rf_exp[i]));
   endtask

   initial begin
      // Reset with both requesters pushing: nothing may be accepted
      reset      = 1'b1;
      req0_valid = 1'b1; req0_reg = 3'd1; req0_data = 16'hDEAD;
      req1_valid = 1'b1; req1_reg = 3'd2; req1_data = 16'hBEEF;
      step();
      mon_en = 1'b1;
      step();
      @(negedge clk);
      chk("rst_reg_write", 32'(reg_write), 32'(0));
      chk("rst_wr_count", 32'(wr_count), 32'(0));
      chk("rst_last_grant", 32'(last_grant), 32'(1));
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset      = 1'b0;
      for (int i = 0; i < 8; i++) chk("rst_rf_zero", 32'(rf[i]), 32'(0));
      glog.delete();

      // Single requester streaming to every register
      for (int i = 0; i < 8; i++) send0(3'(i), 16'(i * 16'h1111));
      step();
      @(negedge clk);
      chk("single_count", 32'(wr_count), 32'(8));
      for (int i = 0; i < 8; i++) chk("single_rf", 32'(rf[i]), 32'(i * 16'h1111));
      chk("single_grants", 32'(glog.size()), 32'(8));

      // Contention: strict alternation starting with the ALU
      do_reset();
      fork
         begin send0(3'd2, 16'hAAA0); send0(3'd2, 16'hAAAA); end
         begin send1(3'd3, 16'h5550); send1(3'd3, 16'h5555); end
      join
      step();
      @(negedge clk);
      chk("cont_count", 32'(wr_count), 32'(4));
      chk("cont_r2", 32'(rf[2]), 32'(16'hAAAA));
      chk("cont_r3", 32'(rf[3]), 32'(16'h5555));
      check_alternating("cont", 4);

      // Same destination from both: serialized, later grant wins
      do_reset();
      fork
         send0(3'd5, 16'h1234);
         send1(3'd5, 16'hBEEF);
      join
      step();
      chk("coll_r5", 32'(rf[5]), 32'(16'hBEEF));
      check_alternating("coll", 2);

      // Hold for three cycles after the first grant; order resumes with the load side
      do_reset();
      fork
         begin send0(3'd1, 16'h0101); send0(3'd1, 16'h0202); end
         begin send1(3'd4, 16'h0404); send1(3'd4, 16'h0808); end
         begin
            @(negedge clk);
            step();
            wb_hold = 1'b1;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("hold_last", 32'(last_grant), 32'(0));
               chk("hold_ready", 32'({req0_ready, req1_ready}), 32'(0));
               step();
            end
            wb_hold = 1'b0;
         end
      join
      step();
      @(negedge clk);
      chk("hold_count", 32'(wr_count), 32'(4));
      chk("hold_r1", 32'(rf[1]), 32'(16'h0202));
      chk("hold_r4", 32'(rf[4]), 32'(16'h0808));
      check_alternating("hold", 4);

      // Reset lands while the write to R7 is on the port: it must be dropped
      do_reset();
      send0(3'd7, 16'h0007);
      step();
      chk("mid_r7_pre", 32'(rf[7]), 32'(16'h0007));
      send0(3'd7, 16'h7777);
      reset = 1'b1;
      step();
      @(negedge clk);
      chk("mid_reg_write", 32'(reg_write), 32'(0));
      chk("mid_wr_count", 32'(wr_count), 32'(0));
      chk("mid_last_grant", 32'(last_grant), 32'(1));
      step();
      reset = 1'b0;
      step();
      chk("mid_r7_post", 32'(rf[7]), 32'(16'h0007));
      chk("sb_drained", 32'(sbq.size()), 32'(0));
      check_rf();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute bound on run time
   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
